// File: rtl/msix_irq_requester_if.sv
// Interrupt request handshake between the requester and the PCIe bridge.
//   intx_msi_request : requester -> bridge, request level
//   intx_msi_vector  : requester -> bridge, vector number, valid while request=1
//   intx_msi_grant   : bridge -> requester, acknowledge (one or more cycles)
// Modports: master = requester side, slave = bridge side.
interface msix_irq_requester_if #(
  parameter int unsigned VECW = 2
) ();
  logic            intx_msi_request;
  logic [VECW-1:0] intx_msi_vector;
  logic            intx_msi_grant;

  modport master (
    output intx_msi_request,
    output intx_msi_vector,
    input  intx_msi_grant
  );

  modport slave (
    input  intx_msi_request,
    input  intx_msi_vector,
    output intx_msi_grant
  );
endinterface

// File: rtl/msix_irq_requester.sv
// Device-side interrupt source controller ahead of the PCIe bridge interrupt port.
// Latches per-vector event pulses into pending bits, masks them, arbitrates round-robin
// among eligible vectors and issues one request at a time on the bridge handshake.
//
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_src_pulse     : one-cycle event per vector (several bits may be set at once)
//   i_vec_mask      : 1 = vector masked (kept pending, not requested)
//   o_pending       : registered pending bits
//   o_busy          : FSM not idle
//   o_timeout_cnt   : saturating count of forced completions (0 unless timeout built in)
//   irq             : request/vector/grant handshake (master modport)
//
// Optional feature: define IRQ_GRANT_TIMEOUT_EN to force completion of a request that has
// not been granted within GNT_TIMEOUT cycles. Without it REQ waits for grant forever.
module msix_irq_requester #(
  parameter int unsigned NVEC        = 4,
  parameter int unsigned VECW        = 2,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NVEC-1:0]      i_src_pulse,
  input  logic [NVEC-1:0]      i_vec_mask,
  output logic [NVEC-1:0]      o_pending,
  output logic                 o_busy,
  output logic [7:0]           o_timeout_cnt,
  msix_irq_requester_if.master irq
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e          r_state;
  logic            r_req;
  logic [VECW-1:0] r_vec;
  logic [VECW-1:0] r_last_vec;
  logic [NVEC-1:0] r_pending;

  logic [NVEC-1:0] w_eligible;
  logic [NVEC-1:0] w_clr;
  logic [VECW-1:0] w_sel;
  logic            w_found;
  logic            w_expire;
  logic            w_done;

`ifdef IRQ_GRANT_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic [7:0]  r_timeouts;

  assign w_expire      = (r_tmo_cnt == 16'(GNT_TIMEOUT - 1));
  assign o_timeout_cnt = r_timeouts;
`else
  logic w_unused_gnt_timeout;

  assign w_unused_gnt_timeout = ^GNT_TIMEOUT;
  assign w_expire             = 1'b0;
  assign o_timeout_cnt        = 8'h00;
`endif

  // Round-robin pick: first eligible index scanning upward from r_last_vec+1, wrapping.
  always_comb begin
    int unsigned idx;
    w_eligible = r_pending & ~i_vec_mask;
    w_sel      = '0;
    w_found    = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NVEC; k++) begin
      idx = (32'(r_last_vec) + k) % NVEC;
      if (!w_found && w_eligible[idx[VECW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[VECW-1:0];
      end
    end
  end

  assign w_done = (r_state == StReq) && (irq.intx_msi_grant || w_expire);
  assign w_clr  = w_done ? (NVEC'(1) << r_vec) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_vec      <= '0;
      r_last_vec <= VECW'(NVEC - 1);
      r_pending  <= '0;
`ifdef IRQ_GRANT_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_timeouts <= '0;
`endif
    end else begin
      // A pulse on the completing edge re-sets the bit being cleared.
      r_pending <= (r_pending & ~w_clr) | i_src_pulse;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_vec   <= w_sel;
            r_req   <= 1'b1;
            r_state <= StReq;
`ifdef IRQ_GRANT_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        StReq: begin
`ifdef IRQ_GRANT_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
`endif
          if (w_done) begin
            r_last_vec <= r_vec;
            r_req      <= 1'b0;
            r_state    <= StGap;
`ifdef IRQ_GRANT_TIMEOUT_EN
            // Grant on the expiry edge is a normal completion.
            if (!irq.intx_msi_grant && (r_timeouts != 8'hFF)) begin
              r_timeouts <= r_timeouts + 8'd1;
            end
`endif
          end
        end
        StGap:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_pending            = r_pending;
  assign o_busy               = (r_state != StIdle);
  assign irq.intx_msi_request = r_req;
  assign irq.intx_msi_vector  = r_vec;

endmodule

// File: tb/tb_msix_irq_requester.sv
module tb_msix_irq_requester;
  localparam int NV = 4;
  localparam int GNT_TIMEOUT = 16;

  logic          clk;
  logic          rst_n;
  logic [NV-1:0] src_pulse;
  logic [NV-1:0] vec_mask;
  logic [NV-1:0] pending;
  logic          busy;
  logic [7:0]    tcnt;

  int n_tests = 0;
  int n_fail  = 0;

  msix_irq_requester_if #(.VECW(2)) irq_if ();

  msix_irq_requester #(
    .NVEC(NV),
    .VECW(2),
    .GNT_TIMEOUT(GNT_TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_src_pulse(src_pulse),
    .i_vec_mask(vec_mask),
    .o_pending(pending),
    .o_busy(busy),
    .o_timeout_cnt(tcnt),
    .irq(irq_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending set, one outstanding request, a cooldown of
  // non-arbitrating cycles after each completion, last-serviced pointer.
  logic [NV-1:0] m_pending;
  bit            m_req;
  int            m_vec, m_last, m_cool, m_wait, m_tcnt;

  task automatic model_reset();
    m_pending = '0; m_req = 0; m_vec = 0; m_last = NV - 1;
    m_cool = 0; m_wait = 0; m_tcnt = 0;
  endtask

  task automatic model_step(input logic [NV-1:0] p, input logic [NV-1:0] m, input logic g);
    int clr;
    logic [NV-1:0] elig;
    bit fin, forced;
    clr = -1;
    elig = m_pending & ~m;
    fin = 0; forced = 0;
    if (m_req) begin
      m_wait++;
      fin = g;
`ifdef IRQ_GRANT_TIMEOUT_EN
      if (!g && m_wait >= GNT_TIMEOUT) begin fin = 1; forced = 1; end
`endif
      if (fin) begin
        clr = m_vec; m_last = m_vec; m_req = 0; m_cool = 1;
        if (forced && m_tcnt < 255) m_tcnt++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (elig != 0) begin
      for (int k = 1; k <= NV; k++) begin
        int idx;
        idx = (m_last + k) % NV;
        if (elig[idx]) begin m_vec = idx; m_req = 1; m_wait = 0; break; end
      end
    end
    if (clr >= 0) m_pending[clr] = 1'b0;
    m_pending = m_pending | p;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_pulse = '0; vec_mask = '0; irq_if.intx_msi_grant = 1'b0;
    #2;
    chk("rst_request", 32'(irq_if.intx_msi_request), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vector", 32'(irq_if.intx_msi_vector), 0);
    chk("rst_tcnt", 32'(tcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit            rst;
    logic [NV-1:0] pulse;
    logic [NV-1:0] mask;
    logic          grant;
    logic [NV-1:0] e_pend;
    logic          e_req;
    logic [1:0]    e_vec;
    logic          e_busy;
  } row_t;

  row_t tbl[$];

  function automatic row_t r(bit rs, logic [3:0] p, logic [3:0] m, logic g,
                             logic [3:0] ep, logic er, logic [1:0] ev, logic eb);
    row_t x;
    x.rst = rs; x.pulse = p; x.mask = m; x.grant = g;
    x.e_pend = ep; x.e_req = er; x.e_vec = ev; x.e_busy = eb;
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    src_pulse = '0; vec_mask = '0; irq_if.intx_msi_grant = 1'b0;
    model_reset();

    // Single event: vector 1, grant 3 cycles after request rises.
    tbl.push_back(r(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(r(0, 4'b0010, 4'b0000, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // Round-robin: all four pending, grant held high.
    tbl.push_back(r(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(r(0, 4'b1111, 4'b0000, 1, 4'b1111, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1111, 1, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1110, 0, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1110, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1110, 1, 1, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1100, 0, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1100, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1100, 1, 2, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b1000, 1, 3, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(r(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        src_pulse = tbl[i].pulse;
        vec_mask = tbl[i].mask;
        irq_if.intx_msi_grant = tbl[i].grant;
        step();
        chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
        chk($sformatf("tbl%0d_request", i), 32'(irq_if.intx_msi_request), 32'(tbl[i].e_req));
        chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        if (tbl[i].e_req)
          chk($sformatf("tbl%0d_vector", i), 32'(irq_if.intx_msi_vector), 32'(tbl[i].e_vec));
      end
    end

    // Masked vector held pending, requested right after unmask.
    do_reset();
    vec_mask = 4'b0100; src_pulse = 4'b0100;
    step();
    src_pulse = '0;
    for (int c = 0; c < 50; c++) begin
      step();
      chk("mask_no_request", 32'(irq_if.intx_msi_request), 0);
      chk("mask_pending", 32'(pending), 32'(4'b0100));
    end
    vec_mask = '0;
    step();
    chk("unmask_request", 32'(irq_if.intx_msi_request), 1);
    chk("unmask_vector", 32'(irq_if.intx_msi_vector), 2);
    irq_if.intx_msi_grant = 1'b1;
    step();
    irq_if.intx_msi_grant = 1'b0;
    chk("unmask_cleared", 32'(pending), 0);

    // Pulse on the grant edge keeps the bit pending and re-requests.
    do_reset();
    src_pulse = 4'b0001;
    step();
    src_pulse = '0;
    step();
    chk("pw_request", 32'(irq_if.intx_msi_request), 1);
    src_pulse = 4'b0001; irq_if.intx_msi_grant = 1'b1;
    step();
    src_pulse = '0; irq_if.intx_msi_grant = 1'b0;
    chk("pw_pending_kept", 32'(pending), 32'(4'b0001));
    chk("pw_req_low", 32'(irq_if.intx_msi_request), 0);
    step();
    chk("pw_idle_low", 32'(irq_if.intx_msi_request), 0);
    step();
    chk("pw_rerequest", 32'(irq_if.intx_msi_request), 1);
    chk("pw_revector", 32'(irq_if.intx_msi_vector), 0);

    // Reset asserted mid-request acts immediately.
    do_reset();
    src_pulse = 4'b0100;
    step();
    src_pulse = '0;
    step();
    chk("mr_request_before", 32'(irq_if.intx_msi_request), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_request_async", 32'(irq_if.intx_msi_request), 0);
    chk("mr_pending_async", 32'(pending), 0);
    chk("mr_busy_async", 32'(busy), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("mr_no_request", 32'(irq_if.intx_msi_request), 0);
      chk("mr_no_pending", 32'(pending), 0);
    end

    // Randomized traffic against the model.
    do_reset();
    begin
      logic [NV-1:0] p, m;
      logic g;
      m = '0;
      for (int c = 0; c < 3000; c++) begin
        p = '0;
        for (int b = 0; b < NV; b++) p[b] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) begin
          for (int b = 0; b < NV; b++) m[b] = ($urandom_range(0, 3) == 0);
        end
        g = ($urandom_range(0, 2) == 0);
        src_pulse = p; vec_mask = m; irq_if.intx_msi_grant = g;
        step();
        model_step(p, m, g);
        chk("rnd_pending", 32'(pending), 32'(m_pending));
        chk("rnd_request", 32'(irq_if.intx_msi_request), 32'(m_req));
        chk("rnd_busy", 32'(busy), 32'(m_req || (m_cool > 0)));
        chk("rnd_tcnt", 32'(tcnt), 32'(m_tcnt));
        if (m_req) chk("rnd_vector", 32'(irq_if.intx_msi_vector), 32'(m_vec));
      end
      src_pulse = '0; irq_if.intx_msi_grant = 1'b0;
    end

`ifdef IRQ_GRANT_TIMEOUT_EN
    // Grant never arrives: every request is forced after GNT_TIMEOUT cycles.
    do_reset();
    for (int rep = 0; rep < 300; rep++) begin
      int hi, w;
      src_pulse = 4'b1000;
      step();
      src_pulse = '0;
      w = 0;
      while (!irq_if.intx_msi_request && w < 4) begin step(); w++; end
      chk("tmo_request_rise", 32'(irq_if.intx_msi_request), 1);
      hi = 0;
      while (irq_if.intx_msi_request && hi < 40) begin step(); hi++; end
      chk("tmo_high_cycles", 32'(hi), 32'(GNT_TIMEOUT));
      chk("tmo_pending_clear", 32'(pending[3]), 0);
      if (rep == 0) chk("tmo_first_count", 32'(tcnt), 1);
    end
    chk("tmo_saturated", 32'(tcnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
